// File: rtl/dice_pkg.sv
// Shared types and helpers for the two-player dice game controller.
//   dice_state_t   : game FSM state encoding
//   DICE_MIN/MAX   : legal face range of a throw
//   is_valid_throw : true when a 3-bit dice code is a legal face (1..6)
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROLL   = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        REROLL = 3'd4,
        ADD    = 3'd5,
        WIN    = 3'd6
    } dice_state_t;

    localparam logic [2:0] DICE_MIN = 3'd1;
    localparam logic [2:0] DICE_MAX = 3'd6;

    // Codes 0 and 7 are produced by the free-running 3-bit dice counter but are not faces.
    function automatic logic is_valid_throw(input logic [2:0] t);
        return (t >= DICE_MIN) && (t <= DICE_MAX);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stable-count filter.
// The output follows the synchronised level only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current output.
//   clk    in  : system clock
//   rst    in  : asynchronous, active-high reset
//   i_din  in  : raw asynchronous button level
//   o_dout out : debounced, registered button level
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout
);
    import dice_pkg::*;

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_dout;
    logic [CNT_W-1:0] r_cnt;

    // Synchroniser and filter: a sample equal to the output restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_dout) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_dout <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/dice_game_ctrl.sv
// Two-player dice game controller. Debounces the player button, drives the
// dice roll enable, captures each settled throw (re-rolling codes 0 and 7),
// accumulates per-player scores and flags the winner at TARGET.
//   clk            in  : system clock
//   rst            in  : asynchronous, active-high reset
//   i_btn_raw      in  : raw player button
//   i_new_game     in  : one-cycle restart request, honoured only in WIN
//   i_throw[2:0]   in  : registered dice counter value
//   o_roll_en      out : dice counter enable
//   o_player       out : player whose turn it is
//   o_score0/1     out : running scores
//   o_result_valid out : one-cycle pulse when a throw is accepted
//   o_result[2:0]  out : last accepted throw
//   o_winner       out : winning player, valid while o_done
//   o_done         out : game over
module dice_game_ctrl #(
    parameter  int unsigned DEBOUNCE_CYCLES = 4,
    parameter  int unsigned TARGET          = 20,
    localparam int unsigned SCORE_W         = $clog2(TARGET + 6)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_btn_raw,
    input  logic               i_new_game,
    input  logic [2:0]         i_throw,
    output logic               o_roll_en,
    output logic               o_player,
    output logic [SCORE_W-1:0] o_score0,
    output logic [SCORE_W-1:0] o_score1,
    output logic               o_result_valid,
    output logic [2:0]         o_result,
    output logic               o_winner,
    output logic               o_done
);
    import dice_pkg::*;

    localparam logic [SCORE_W-1:0] TARGET_S = SCORE_W'(TARGET);

    dice_state_t        r_state;
    dice_state_t        w_state_nxt;

    logic               w_btn_db;
    logic               r_btn_db_d;
    logic               w_btn_rise;
    logic               w_btn_fall;

    logic               r_roll_en;
    logic               r_result_valid;
    logic               r_done;
    logic               r_player;
    logic               r_winner;
    logic [2:0]         r_result;
    logic [SCORE_W-1:0] r_score0;
    logic [SCORE_W-1:0] r_score1;

    logic               w_roll_en_nxt;
    logic               w_result_valid_nxt;
    logic               w_done_nxt;
    logic               w_latch_result;
    logic               w_add;
    logic               w_win;
    logic               w_clear;
    logic [SCORE_W-1:0] w_cur_score;
    logic [SCORE_W-1:0] w_sum;
    logic               w_reach;

    // Button conditioning.
    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .i_din  (i_btn_raw),
        .o_dout (w_btn_db)
    );

    assign w_btn_rise = w_btn_db & ~r_btn_db_d;
    assign w_btn_fall = ~w_btn_db & r_btn_db_d;

    // Score of the player on turn plus the latched throw; cannot wrap since score < TARGET here.
    assign w_cur_score = r_player ? r_score1 : r_score0;
    assign w_sum       = w_cur_score + SCORE_W'(r_result);
    assign w_reach     = (w_sum >= TARGET_S);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_state_nxt        = r_state;
        w_latch_result     = 1'b0;
        w_add              = 1'b0;
        w_win              = 1'b0;
        w_clear            = 1'b0;
        w_roll_en_nxt      = 1'b0;
        w_result_valid_nxt = 1'b0;
        w_done_nxt         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_btn_rise) begin
                    w_state_nxt = ROLL;
                end
            end
            ROLL: begin
                if (w_btn_fall) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                w_state_nxt = CHECK;
            end
            CHECK: begin
                if (is_valid_throw(i_throw)) begin
                    w_latch_result = 1'b1;
                    w_state_nxt    = ADD;
                end else begin
                    w_state_nxt = REROLL;
                end
            end
            REROLL: begin
                w_state_nxt = SETTLE;
            end
            ADD: begin
                w_add = 1'b1;
                if (w_reach) begin
                    w_win       = 1'b1;
                    w_state_nxt = WIN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WIN: begin
                if (i_new_game) begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they change only at clock edges.
        w_roll_en_nxt      = (w_state_nxt == ROLL) || (w_state_nxt == REROLL);
        w_result_valid_nxt = (w_state_nxt == ADD);
        w_done_nxt         = (w_state_nxt == WIN);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_db_d     <= 1'b0;
            r_roll_en      <= 1'b0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
            r_player       <= 1'b0;
            r_winner       <= 1'b0;
            r_result       <= 3'd0;
            r_score0       <= '0;
            r_score1       <= '0;
        end else begin
            r_btn_db_d     <= w_btn_db;
            r_roll_en      <= w_roll_en_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_done         <= w_done_nxt;

            if (w_latch_result) begin
                r_result <= i_throw;
            end

            if (w_add) begin
                if (r_player) begin
                    r_score1 <= w_sum;
                end else begin
                    r_score0 <= w_sum;
                end
                if (w_win) begin
                    r_winner <= r_player;
                end else begin
                    r_player <= ~r_player;
                end
            end

            if (w_clear) begin
                r_score0 <= '0;
                r_score1 <= '0;
                r_player <= 1'b0;
            end
        end
    end

    assign o_roll_en      = r_roll_en;
    assign o_player       = r_player;
    assign o_score0       = r_score0;
    assign o_score1       = r_score1;
    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;
    assign o_winner       = r_winner;
    assign o_done         = r_done;

endmodule

// File: doc/dice_game_ctrl.md
# dice_game_ctrl

Two-player game controller for the electronic dice counter. Debounces the raw player button, drives the dice's roll enable, captures each settled throw, rejects the out-of-range codes 0 and 7 by re-rolling, and keeps per-player running scores. It declares a winner when a score reaches a target. Sits between the board push-button and the `dice` counter, and feeds the display/LED logic.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required before the debounced button changes; must be ≥1.
- `TARGET`, 20: winning score; must be ≥1.
- `SCORE_W`, `$clog2(TARGET+6)`: score width, derived and not overridden.
- Reset `rst` is asynchronous and active-high. Clock is `clk`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn_raw` in 1: raw, asynchronous player button.
- `new_game` in 1: synchronous one-cycle request; honoured only in `WIN`.
- `throw` in 3: dice counter output, registered in the dice.
- `roll_en` out 1: drives the dice `button` input.
- `player` out 1: player whose turn it is (0/1).
- `score0` out `SCORE_W`: player 0 score.
- `score1` out `SCORE_W`: player 1 score.
- `result_valid` out 1: one-cycle pulse when a throw is accepted.
- `result` out 3: accepted throw value (1..6); valid with `result_valid`, holds its value otherwise.
- `winner` out 1: winning player; valid while `done`.
- `done` out 1: high in `WIN`.

## Operation
- **Input path:** `btn_raw` passes through a 2-FF synchroniser. The debouncer then sets `btn_db` to the synchronised level only after `DEBOUNCE_CYCLES` consecutive equal samples; any differing sample restarts the count.
- **States:** `IDLE`, `ROLL`, `SETTLE`, `CHECK`, `REROLL`, `ADD`, `WIN`.
- **IDLE:** `roll_en` = 0. A rising edge of `btn_db` moves to `ROLL`.
- **ROLL:** `roll_en` = 1. Stays while `btn_db` = 1; a falling edge of `btn_db` moves to `SETTLE`.
- **SETTLE:** `roll_en` = 0. Always moves to `CHECK` next cycle.
- **CHECK:** samples `throw`. A value of 1..6 is latched into `result` and moves to `ADD`. A value of 0 or 7 moves to `REROLL`.
- **REROLL:** `roll_en` = 1 for exactly one cycle, then `SETTLE`. The counter advances by 1 per pass, so at most 2 passes are needed.
- **ADD:** `result_valid` = 1. The current player's score becomes score + `result`.
  - If the new score ≥ `TARGET`: `winner` ← `player`, go to `WIN`, `player` unchanged.
  - Otherwise: toggle `player`, go to `IDLE`.
- **WIN:** `done` = 1; button activity is ignored. `new_game` clears both scores, sets `player` ← 0, and goes to `IDLE`. `new_game` is ignored in all other states.
- **Arithmetic:** unsigned. The maximum stored value is `TARGET`−1+6, which fits in `SCORE_W`; there is no saturation or wrap.
- **Reset (any state, including mid-roll):** state `IDLE`, synchroniser/debounce state 0, `btn_db` 0, both scores 0, `player` 0, `winner` 0, `result` 0. `roll_en`, `result_valid` and `done` are all 0.
- **Button held at reset release:** treated as a rising edge once debounced, so a roll starts.

## Timing
- `roll_en`, `result_valid` and `done` are decoded from the state register; they are glitch-free and change only at clock edges.
- Edge E is the edge at which `btn_db` goes high. `roll_en` rises at E+1.
- Debounce latency from a `btn_raw` change to the `btn_db` change is 2 + `DEBOUNCE_CYCLES` cycles. A bounce shorter than that produces no edge.
- Edge F is the edge at which `btn_db` goes low. Timing from F:
  - F+1: `SETTLE`, `roll_en` low. The dice's final increment occurred at F+1.
  - F+2: `CHECK`.
  - F+3: `ADD`, `result_valid` high for one cycle.
  - F+4: the score is visible.
- Each rejected throw adds 3 cycles (`REROLL`, `SETTLE`, `CHECK`).
- `done` rises one cycle after the winning `ADD` cycle. It falls the cycle after `new_game` is sampled in `WIN`.

## Structure
- Shared package `dice_pkg` holds:
  - the state enum `dice_state_t`;
  - constants `DICE_MIN` = 3'd1 and `DICE_MAX` = 3'd6;
  - the function `is_valid_throw`.
- Sub-module `button_debounce` (`clk`, `rst`, `DEBOUNCE_CYCLES`, `din` → `dout`) contains the synchroniser and the stable-count filter. The FSM and score registers stay in `dice_game_ctrl`.
- The testbench instantiates `dice_game_ctrl` together with the real `dice` counter.

## Test plan
- **Debounce:** `DEBOUNCE_CYCLES`=4. Toggle `btn_raw` high for 3 cycles, low for 3, high for 3 → `btn_db` stays 0 and `roll_en` is never asserted.
- **Basic turn:** reset, dice at 0. Debounced press lasting 3 `roll_en` cycles → dice = 3, `result` = 3, `result_valid` exactly at F+3, `score0` = 3, `player` = 1.
- **Reject and re-roll:** roll leaves the dice at 7 → one `REROLL` pass, dice wraps to 0, second `REROLL`, dice = 1 → `result` = 1, single `result_valid`.
- **Win:** `TARGET`=20, `score1`=17, player 1 throws 4 → `score1` = 21, `done` = 1, `winner` = 1. Button presses then change nothing. `new_game` → scores 0, `player` 0, `done` 0.
- **Reset mid-roll:** assert `rst` during `ROLL` with `score0`=9 → `roll_en` 0 immediately, scores 0, state `IDLE`. Release with button low → no roll.
- **`new_game` outside `WIN`:** pulse `new_game` in `IDLE` with `score0`=5 → no effect.
